// File: rtl/core_inst_seq.sv
// core_inst_seq: host-driven instruction sequencer for the attention core.
// Writes total_cycle Q vectors and col K vectors into the core memories,
// loads K into the array, executes total_cycle dot-product steps, then
// drains the output FIFO into pmem. The instruction word and memory data bus
// are registered, so each word appears one cycle after the state that
// produced it.
// total_cycle and col must each be at most 16 because the address fields
// are 4 bits wide.
module core_inst_seq #(
   parameter int total_cycle = 8,
   parameter int col         = 8,
   parameter int pr          = 8,
   parameter int bw          = 8,
   parameter int gap_q       = 3,
   parameter int gap_k       = 2,
   parameter int gap_load    = 10,
   parameter int gap_exec    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [pr*bw-1:0] in_data,
   output logic             in_ready,
   output logic [16:0]      inst,
   output logic [pr*bw-1:0] mem_in,
   output logic             busy,
   output logic             done
);

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One counter serves both the gap countdowns and the 0..N-1 address ramps,
   // so it must cover the largest of all of them (and at least the 4-bit
   // address field).
   localparam int cnt_span = imax(imax(imax(total_cycle, col), imax(gap_q, gap_k)),
                                  imax(gap_load, gap_exec));
   localparam int cnt_w    = imax(4, $clog2(cnt_span + 1));

   typedef logic [cnt_w-1:0] cnt_t;

   localparam cnt_t q_last  = cnt_t'(total_cycle - 1);
   localparam cnt_t k_last  = cnt_t'(col - 1);
   localparam cnt_t gq_init = cnt_t'((gap_q    > 0) ? gap_q    - 1 : 0);
   localparam cnt_t gk_init = cnt_t'((gap_k    > 0) ? gap_k    - 1 : 0);
   localparam cnt_t gl_init = cnt_t'((gap_load > 0) ? gap_load - 1 : 0);
   localparam cnt_t ge_init = cnt_t'((gap_exec > 0) ? gap_exec - 1 : 0);

   // Instruction word bit positions.
   localparam int b_ofifo_rd = 16;
   localparam int b_execute  = 7;
   localparam int b_load     = 6;
   localparam int b_qmem_rd  = 5;
   localparam int b_qmem_wr  = 4;
   localparam int b_kmem_rd  = 3;
   localparam int b_kmem_wr  = 2;
   localparam int b_pmem_wr  = 0;

   typedef enum logic [3:0] {
      IDLE, QWR, GAPQ, KWR, GAPK, KLOAD, KTAIL, GAPL, EXEC, GAPE, DRAIN, DONE
   } state_t;

   state_t             state, state_d;
   cnt_t               cnt, cnt_d;
   logic [16:0]        inst_d;
   logic [pr*bw-1:0]   mem_in_d;
   logic               busy_d, done_d;

   assign in_ready = (state == QWR) || (state == KWR);

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         inst   <= '0;
         mem_in <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values
         // of the others, independent of statement order.
         state  <= state_d;
         cnt    <= cnt_d;
         inst   <= inst_d;
         mem_in <= mem_in_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end

   // Next state, counter and the instruction word for the following cycle.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d  = state;
      cnt_d    = cnt;
      inst_d   = '0;
      mem_in_d = mem_in;
      done_d   = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_d = QWR;
               cnt_d   = '0;
            end
         end
         QWR: begin
            if (in_valid) begin
               inst_d[b_qmem_wr] = 1'b1;
               inst_d[15:12]     = cnt[3:0];
               mem_in_d          = in_data;
               if (cnt == q_last) begin
                  state_d = (gap_q > 0) ? GAPQ : KWR;
                  cnt_d   = (gap_q > 0) ? gq_init : '0;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
         GAPQ: begin
            if (cnt == '0) state_d = KWR;
            else           cnt_d   = cnt - 1'b1;
         end
         KWR: begin
            if (in_valid) begin
               inst_d[b_kmem_wr] = 1'b1;
               inst_d[15:12]     = cnt[3:0];
               mem_in_d          = in_data;
               if (cnt == k_last) begin
                  state_d = (gap_k > 0) ? GAPK : KLOAD;
                  cnt_d   = (gap_k > 0) ? gk_init : '0;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
         GAPK: begin
            if (cnt == '0) state_d = KLOAD;
            else           cnt_d   = cnt - 1'b1;
         end
         KLOAD: begin
            inst_d[b_load]    = 1'b1;
            inst_d[b_kmem_rd] = 1'b1;
            inst_d[15:12]     = cnt[3:0];
            if (cnt == k_last) begin
               state_d = KTAIL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         KTAIL: begin
            // Extra load beat with kmem_rd low flushes the last K vector in.
            inst_d[b_load] = 1'b1;
            state_d        = (gap_load > 0) ? GAPL : EXEC;
            cnt_d          = (gap_load > 0) ? gl_init : '0;
         end
         GAPL: begin
            if (cnt == '0) state_d = EXEC;
            else           cnt_d   = cnt - 1'b1;
         end
         EXEC: begin
            inst_d[b_execute] = 1'b1;
            inst_d[b_qmem_rd] = 1'b1;
            inst_d[15:12]     = cnt[3:0];
            if (cnt == q_last) begin
               state_d = (gap_exec > 0) ? GAPE : DRAIN;
               cnt_d   = (gap_exec > 0) ? ge_init : '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         GAPE: begin
            if (cnt == '0) state_d = DRAIN;
            else           cnt_d   = cnt - 1'b1;
         end
         DRAIN: begin
            inst_d[b_ofifo_rd] = 1'b1;
            inst_d[b_pmem_wr]  = 1'b1;
            inst_d[11:8]       = cnt[3:0];
            if (cnt == q_last) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // busy stays high through the cycle that carries the done pulse.
      busy_d = (state_d != IDLE) || (state == DONE);
   end

endmodule

// File: tb/tb_core_inst_seq.sv
// tb_core_inst_seq: randomized bench for core_inst_seq. A timeline model
// lists, slot by slot, the instruction word, data bus, done flag and
// in_ready expected after each clock edge of a run, and the bench compares
// the DUT against it. Instance A uses default parameters, instance B uses
// total_cycle=4, col=16, gap_k=0.
module tb_core_inst_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_a, start_b;
   logic        in_valid;
   logic [63:0] in_data;

   logic        in_ready_a, busy_a, done_a;
   logic [16:0] inst_a;
   logic [63:0] mem_in_a;
   logic        in_ready_b, busy_b, done_b;
   logic [16:0] inst_b;
   logic [63:0] mem_in_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   core_inst_seq dut_a (
      .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_a), .inst(inst_a), .mem_in(mem_in_a), .busy(busy_a), .done(done_a)
   );

   core_inst_seq #(.total_cycle(4), .col(16), .gap_k(0)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_b), .inst(inst_b), .mem_in(mem_in_b), .busy(busy_b), .done(done_b)
   );

   // Outputs of the instance currently under test.
   int          sel = 0;
   logic [16:0] o_inst;
   logic [63:0] o_mem;
   logic        o_rdy, o_busy, o_done;
   assign o_inst = (sel != 0) ? inst_b     : inst_a;
   assign o_mem  = (sel != 0) ? mem_in_b   : mem_in_a;
   assign o_rdy  = (sel != 0) ? in_ready_b : in_ready_a;
   assign o_busy = (sel != 0) ? busy_b     : busy_a;
   assign o_done = (sel != 0) ? done_b     : done_a;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected timeline: slot k is what the DUT shows after edge k+1 of a run.
   logic [16:0] e_inst[$];
   logic [63:0] e_mem[$];
   bit          e_done[$];
   bit          e_rdy[$];
   bit          s_val[$];
   logic [63:0] s_dat[$];
   logic [63:0] model_mem[2] = '{64'd0, 64'd0};

   task automatic push(input logic [16:0] i, input logic [63:0] m, input bit d,
                       input bit r, input bit v, input logic [63:0] dat);
      e_inst.push_back(i);
      e_mem.push_back(m);
      e_done.push_back(d);
      e_rdy.push_back(r);
      s_val.push_back(v);
      s_dat.push_back(dat);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // gap_mode: 0 back-to-back beats, 1 one idle cycle before each beat,
   // 2 random 0..2 idle cycles. poke pulses start in the middle of EXEC.
   task automatic run_seq(input int which, input int tc, input int cl, input int gq,
                          input int gk, input int gl, input int ge, input int gap_mode,
                          input bit poke, input string name);
      logic [63:0] m;
      logic [63:0] d;
      int          poke_k;
      int          n;
      e_inst.delete(); e_mem.delete(); e_done.delete();
      e_rdy.delete(); s_val.delete(); s_dat.delete();
      m      = model_mem[which];
      poke_k = -1;

      // Host write phases: Q then K, each followed by its gap.
      for (int ph = 0; ph < 2; ph++) begin
         n = (ph != 0) ? cl : tc;
         for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < g; j++) push(17'd0, m, 1'b0, 1'b1, 1'b0, rnd64());
            d = rnd64();
            m = d;
            push(17'((((ph != 0) ? 4 : 16)) + (i << 12)), m, 1'b0, 1'b1, 1'b1, d);
         end
         // Beats offered during the gap must be ignored.
         for (int j = 0; j < ((ph != 0) ? gk : gq); j++)
            push(17'd0, m, 1'b0, 1'b0, 1'b1, rnd64());
      end
      for (int i = 0; i < cl; i++) push(17'(64 + 8 + (i << 12)), m, 1'b0, 1'b0, 1'b1, rnd64());
      push(17'd64, m, 1'b0, 1'b0, 1'b1, rnd64());
      for (int j = 0; j < gl; j++) push(17'd0, m, 1'b0, 1'b0, 1'b1, rnd64());
      poke_k = e_inst.size() + 1;
      for (int i = 0; i < tc; i++) push(17'(128 + 32 + (i << 12)), m, 1'b0, 1'b0, 1'b1, rnd64());
      for (int j = 0; j < ge; j++) push(17'd0, m, 1'b0, 1'b0, 1'b1, rnd64());
      for (int i = 0; i < tc; i++) push(17'(65536 + 1 + (i << 8)), m, 1'b0, 1'b0, 1'b1, rnd64());
      push(17'd0, m, 1'b1, 1'b0, 1'b0, 64'd0);

      sel = which;
      @(negedge clk);
      if (which != 0) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      n = e_inst.size();
      for (int k = 0; k <= n + 1; k++) begin
         if (k == 0) begin
            check($sformatf("%s inst after start", name), 64'(o_inst), 64'd0);
            check($sformatf("%s mem after start", name), o_mem, model_mem[which]);
            check($sformatf("%s done after start", name), 64'(o_done), 64'd0);
         end else if (k <= n) begin
            check($sformatf("%s inst[%0d]", name, k - 1), 64'(o_inst), 64'(e_inst[k-1]));
            check($sformatf("%s mem[%0d]", name, k - 1), o_mem, e_mem[k-1]);
            check($sformatf("%s done[%0d]", name, k - 1), 64'(o_done), 64'(e_done[k-1]));
         end else begin
            check($sformatf("%s inst idle", name), 64'(o_inst), 64'd0);
            check($sformatf("%s done idle", name), 64'(o_done), 64'd0);
         end
         check($sformatf("%s busy[%0d]", name, k), 64'(o_busy), (k <= n) ? 64'd1 : 64'd0);
         check($sformatf("%s in_ready[%0d]", name, k), 64'(o_rdy),
               (k < n) ? 64'(e_rdy[k]) : 64'd0);
         in_valid = (k < n) ? s_val[k] : 1'b0;
         in_data  = (k < n) ? s_dat[k] : rnd64();
         if (which != 0) start_b = poke && (k == poke_k);
         else            start_a = poke && (k == poke_k);
         @(negedge clk);
      end
      start_a  = 1'b0;
      start_b  = 1'b0;
      in_valid = 1'b0;
      model_mem[which] = m;
   endtask

   task automatic reset_abort();
      bit found;
      found = 1'b0;
      sel   = 0;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a  = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         in_data = rnd64();
         @(negedge clk);
         if (inst_a[6] && inst_a[3] && inst_a[15:12] == 4'd3) begin
            found = 1'b1;
            break;
         end
      end
      check("abort reached kload addr 3", 64'(found), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("abort inst", 64'(inst_a), 64'd0);
      check("abort busy", 64'(busy_a), 64'd0);
      check("abort done", 64'(done_a), 64'd0);
      check("abort mem_in", mem_in_a, 64'd0);
      check("abort in_ready", 64'(in_ready_a), 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort done held", 64'(done_a), 64'd0);
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      model_mem[0] = 64'd0;
      model_mem[1] = 64'd0;
      repeat (2) @(negedge clk);
      check("after abort idle busy", 64'(busy_a), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b0;
      start_a  = 1'b0;
      start_b  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      #1;
      check("reset inst", 64'(inst_a), 64'd0);
      check("reset busy", 64'(busy_a), 64'd0);
      check("reset done", 64'(done_a), 64'd0);
      check("reset mem_in", mem_in_a, 64'd0);
      check("reset in_ready", 64'(in_ready_a), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      run_seq(0, 8, 8, 3, 2, 10, 10, 0, 1'b0, "a_b2b");
      run_seq(0, 8, 8, 3, 2, 10, 10, 1, 1'b1, "a_alt_poke");
      run_seq(0, 8, 8, 3, 2, 10, 10, 2, 1'b0, "a_rand");
      run_seq(1, 4, 16, 3, 0, 10, 10, 2, 1'b0, "b_nogapk");
      reset_abort();
      run_seq(0, 8, 8, 3, 2, 10, 10, 2, 1'b0, "a_restart");
      run_seq(1, 4, 16, 3, 0, 10, 10, 0, 1'b1, "b_b2b_poke");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
